mux4_1: RTL and testbench
=========================

MUX4_1 -- requirements
Module: mux4_1

Interface
Parameters (name, default, meaning):
- REQ-001 The block SHALL have parameter WIDTH, default 1, giving the bit width of each of the four data lanes; legal range is 1 to 64.
- REQ-002 The block SHALL have parameter REG_OUT, default 0: 0 means `out` is combinational, 1 means `out` equals `out_q`.

Ports (name, direction, width, meaning):
- REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
- REQ-005 The block SHALL have port in, input, 4*WIDTH: four packed lanes; lane k occupies bits [k*WIDTH +: WIDTH].
- REQ-006 The block SHALL have port select, input, 2: lane index 0 to 3.
- REQ-007 The block SHALL have port out, output, WIDTH: selected lane (combinational, or registered per REG_OUT).
- REQ-008 The block SHALL have port out_q, output, WIDTH: selected lane registered on the clk rising edge.
- REQ-009 The block SHALL have port sel_q, output, 2: select value registered alongside out_q.

Function
- REQ-010 For the combinational path, the block SHALL drive the selected lane as in[select*WIDTH +: WIDTH], i.e. select=00 gives lane 0, 01 lane 1, 10 lane 2, 11 lane 3.
- REQ-011 With REG_OUT=0, out SHALL equal the combinational selection with zero clock latency and no dependence on clk or rst_n.
- REQ-012 With REG_OUT=1, out SHALL equal out_q.
- REQ-013 On each clk rising edge with rst_n high, out_q SHALL load the combinational selection and sel_q SHALL load select, giving exactly 1 cycle of latency.
- REQ-014 All four select codes SHALL be valid; there is no illegal code and no default or error output.
- REQ-015 If select or in contains X or Z, the combinational output SHALL be permitted to be X in simulation; synthesized logic SHALL be a pure 4:1 mux per bit.
- REQ-016 The combinational path SHALL contain no latches and no inferred storage.
- REQ-017 Simultaneous changes of in and select SHALL settle combinationally to the selection given by the new values.

Reset
- REQ-018 When rst_n goes low, out_q SHALL be cleared to all zeros and sel_q to 00 immediately, without waiting for a clock edge.
- REQ-019 While rst_n is low, out_q and sel_q SHALL hold zero regardless of clk, in or select.
- REQ-020 With REG_OUT=0, out SHALL remain functional during reset.
- REQ-021 With REG_OUT=1, out SHALL read zero during reset.
- REQ-022 rst_n deassertion SHALL be synchronized internally with a 2-flop release synchronizer, so that registers resume loading on the second rising edge after deassertion.
- REQ-023 Reset asserted mid-operation SHALL discard any registered value; there is no other state.

Verification
- REQ-024 With REG_OUT=0 and WIDTH=1, the bench SHALL sweep all 16 values of in against every select code and check out against the value of in[select] each time.
- REQ-025 The bench SHALL check these combinational cases:
  - in=0001, select=10 -> out=0.
  - in=0100, select=10 -> out=1.
  - in=0110, select=11 -> out=0.
  - in=1011, select=01 -> out=1.
  - in=0010, select=01 -> out=1.
  - in=1111, select=00 -> out=1.
- REQ-026 Registered path: with in=1101 and select=10 applied before an edge, out_q SHALL be 1 and sel_q SHALL be 10 after that edge, and out_q SHALL be unchanged before it.
- REQ-027 Asynchronous reset: with out_q=1, dropping rst_n between edges SHALL make out_q=0 and sel_q=00 immediately, and the first load after release SHALL occur on the second rising edge.
- REQ-028 With WIDTH=8, in=0xDD_CC_BB_AA and select=11, out SHALL be 0xDD; with select=00, out SHALL be 0xAA.
- REQ-029 With REG_OUT=1, out SHALL track out_q exactly, with 1 cycle of lag relative to the combinational selection.

Source files
------------

// File: rtl/mux4_1.sv
// rtl/mux4_1.sv - four-lane selector with optional registered output and release-synchronized reset
module mux4_1 #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] in,
    input  logic [1:0]         select,
    output logic [WIDTH-1:0]   out,
    output logic [WIDTH-1:0]   out_q,
    output logic [1:0]         sel_q
);

    logic [WIDTH-1:0] lane_sel;
    logic             run_q;

    always_comb begin
        lane_sel = in[select*WIDTH +: WIDTH];
    end

    // First release stage; out_q/sel_q act as the second stage, so the first
    // load lands on the second rising edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            sel_q <= 2'b00;
        end else if (run_q) begin
            out_q <= lane_sel;
            sel_q <= select;
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            assign out = out_q;
        end else begin : g_comb_out
            assign out = lane_sel;
        end
    endgenerate

endmodule

// File: tb/tb_mux4_1.sv
// tb/tb_mux4_1.sv - scoreboard bench for mux4_1 (combinational, registered and 8-bit variants)
module tb_mux4_1;

    localparam int S_C_OUT = 0;
    localparam int S_C_OQ  = 1;
    localparam int S_C_SQ  = 2;
    localparam int S_R_OUT = 3;
    localparam int S_R_OQ  = 4;
    localparam int S_R_SQ  = 5;
    localparam int S_W_OUT = 6;
    localparam int S_W_OQ  = 7;
    localparam int S_W_SQ  = 8;

    typedef struct {
        int          sig;
        logic [7:0]  exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_c;
    logic [1:0]  sel_c;
    logic [31:0] in_w;
    logic [1:0]  sel_w;

    logic        c_out, c_out_q, r_out, r_out_q;
    logic [1:0]  c_sel_q, r_sel_q, w_sel_q;
    logic [7:0]  w_out, w_out_q;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux4_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .in(in_c), .select(sel_c),
        .out(c_out), .out_q(c_out_q), .sel_q(c_sel_q)
    );

    mux4_1 #(.WIDTH(1), .REG_OUT(1'b1)) u_r (
        .clk(clk), .rst_n(rst_n), .in(in_c), .select(sel_c),
        .out(r_out), .out_q(r_out_q), .sel_q(r_sel_q)
    );

    mux4_1 #(.WIDTH(8), .REG_OUT(1'b0)) u_w (
        .clk(clk), .rst_n(rst_n), .in(in_w), .select(sel_w),
        .out(w_out), .out_q(w_out_q), .sel_q(w_sel_q)
    );

    function automatic logic [7:0] actual(int sig);
        case (sig)
            S_C_OUT: return {7'd0, c_out};
            S_C_OQ:  return {7'd0, c_out_q};
            S_C_SQ:  return {6'd0, c_sel_q};
            S_R_OUT: return {7'd0, r_out};
            S_R_OQ:  return {7'd0, r_out_q};
            S_R_SQ:  return {6'd0, r_sel_q};
            S_W_OUT: return w_out;
            S_W_OQ:  return w_out_q;
            S_W_SQ:  return {6'd0, w_sel_q};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic expect_v(input int sig, input logic [7:0] v, input string nm);
        exp_t e;
        e.sig  = sig;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks every queued expectation on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t       e;
                logic [7:0] a;
                e = sb.pop_front();
                a = actual(e.sig);
                checks++;
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
                end
            end
        end
    end

    logic [3:0] d_in  [6] = '{4'b0001, 4'b0100, 4'b0110, 4'b1011, 4'b0010, 4'b1111};
    logic [1:0] d_sel [6] = '{2'b10,   2'b10,   2'b11,   2'b01,   2'b01,   2'b00};
    logic       d_exp [6] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1};

    initial begin
        logic       prev_exp;
        logic [1:0] prev_sel;
        logic       e_bit;

        rst_n = 1'b0;
        in_c  = 4'b0100;
        sel_c = 2'b10;
        in_w  = 32'd0;
        sel_w = 2'b00;

        step();
        expect_v(S_C_OUT, 8'd1, "comb_in_reset");
        expect_v(S_C_OQ,  8'd0, "oq_in_reset");
        expect_v(S_C_SQ,  8'd0, "sq_in_reset");
        expect_v(S_R_OUT, 8'd0, "regout_in_reset");

        step();
        rst_n = 1'b1;
        expect_v(S_C_OQ, 8'd0, "oq_after_release");
        step();
        expect_v(S_C_OQ,  8'd0, "no_load_edge1");
        expect_v(S_R_OUT, 8'd0, "regout_edge1");
        step();
        expect_v(S_C_OQ, 8'd1, "load_edge2");
        expect_v(S_C_SQ, 8'd2, "sel_edge2");

        prev_exp = 1'b1;
        prev_sel = 2'b10;
        for (int v = 0; v < 16; v++) begin
            for (int s = 0; s < 4; s++) begin
                step();
                in_c  = 4'(v);
                sel_c = 2'(s);
                e_bit = in_c[sel_c];
                expect_v(S_C_OUT, {7'd0, e_bit},    $sformatf("sweep_out_in%0h_s%0d", v, s));
                expect_v(S_C_OQ,  {7'd0, prev_exp}, $sformatf("sweep_oq_in%0h_s%0d", v, s));
                expect_v(S_C_SQ,  {6'd0, prev_sel}, $sformatf("sweep_sq_in%0h_s%0d", v, s));
                expect_v(S_R_OUT, {7'd0, prev_exp}, $sformatf("sweep_regout_in%0h_s%0d", v, s));
                prev_exp = e_bit;
                prev_sel = sel_c;
            end
        end

        for (int i = 0; i < 6; i++) begin
            step();
            in_c  = d_in[i];
            sel_c = d_sel[i];
            expect_v(S_C_OUT, {7'd0, d_exp[i]}, $sformatf("dir%0d", i));
        end

        step();
        in_c  = 4'b0000;
        sel_c = 2'b00;
        expect_v(S_C_OUT, 8'd0, "zero_vec");
        step();
        in_c  = 4'b1101;
        sel_c = 2'b10;
        expect_v(S_C_OQ, 8'd0, "oq_before_edge");
        step();
        expect_v(S_C_OQ,  8'd1, "oq_after_edge");
        expect_v(S_C_SQ,  8'd2, "sq_after_edge");
        expect_v(S_R_OUT, 8'd1, "regout_after_edge");
        expect_v(S_R_OQ,  8'd1, "r_oq_after_edge");
        expect_v(S_R_SQ,  8'd2, "r_sq_after_edge");

        step();
        #1 rst_n = 1'b0;
        expect_v(S_C_OQ,  8'd0, "async_clear_oq");
        expect_v(S_C_SQ,  8'd0, "async_clear_sq");
        expect_v(S_R_OUT, 8'd0, "async_clear_regout");
        expect_v(S_C_OUT, 8'd1, "comb_during_reset");
        step();
        rst_n = 1'b1;
        expect_v(S_C_OQ, 8'd0, "rel_hold");
        step();
        expect_v(S_C_OQ, 8'd0, "rel_edge1_oq");
        expect_v(S_C_SQ, 8'd0, "rel_edge1_sq");
        step();
        expect_v(S_C_OQ, 8'd1, "rel_edge2_oq");
        expect_v(S_C_SQ, 8'd2, "rel_edge2_sq");

        step();
        in_w  = 32'hDDCC_BBAA;
        sel_w = 2'b11;
        expect_v(S_W_OUT, 8'hDD, "w8_sel3");
        step();
        sel_w = 2'b00;
        expect_v(S_W_OUT, 8'hAA, "w8_sel0");
        step();
        sel_w = 2'b01;
        expect_v(S_W_OUT, 8'hBB, "w8_sel1");
        step();
        sel_w = 2'b10;
        expect_v(S_W_OUT, 8'hCC, "w8_sel2");
        step();
        expect_v(S_W_OQ, 8'hCC, "w8_oq");
        expect_v(S_W_SQ, 8'd2,  "w8_sq");

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            step();
        end
        step();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
